// File: rtl/mux_scan_if.sv
// mux_scan_if: channel data, controls and registered
// selector outputs of the mux_scan block.
interface mux_scan_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  logic [CHANNELS*WIDTH-1:0] x;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS-1:0]       en_mask;
  logic                      hold;
  logic [WIDTH-1:0]          out;
  logic [SEL_W-1:0]          out_ch;
  logic                      out_valid;
  logic                      wrap;

  modport master (
    output x, mode, sel, en_mask, hold,
    input  out, out_ch, out_valid, wrap
  );

  modport slave (
    input  x, mode, sel, en_mask, hold,
    output out, out_ch, out_valid, wrap
  );
endinterface

// File: rtl/mux_scan.sv
// mux_scan: registered N-channel mux with static select
// and round-robin scan over enabled channels.
module mux_scan #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 8
) (
  input logic     clk,
  input logic     rst,
  mux_scan_if.slave bus
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DWELL - 1);

  localparam logic [1:0] S_STATIC = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_EMPTY  = 2'd2;

  logic [1:0]       state, state_n;
  logic [SEL_W-1:0] p, p_n, p_inc;
  logic [CW-1:0]    c, c_n;
  logic [WIDTH-1:0] out_n;
  logic [SEL_W-1:0] ch_n;
  logic             valid_n, wrap_n;
  logic             sel_ok, cur_on;

  function automatic logic bit_at(
    input logic [CHANNELS-1:0] m,
    input logic [SEL_W-1:0]    i
  );
    logic [CHANNELS-1:0] s;
    s = m >> i;
    return s[0];
  endfunction

  function automatic logic [WIDTH-1:0] lane(
    input logic [CHANNELS*WIDTH-1:0] v,
    input logic [SEL_W-1:0]          i
  );
    logic [CHANNELS*WIDTH-1:0] s;
    s = v >> (int'(i) * WIDTH);
    return s[WIDTH-1:0];
  endfunction

  // First enabled channel at or after base, cyclically.
  function automatic logic [SEL_W-1:0] find(
    input logic [SEL_W-1:0]    base,
    input logic [CHANNELS-1:0] m
  );
    logic [SEL_W-1:0]    r;
    logic [CHANNELS-1:0] s;
    logic                hit;
    int                  idx;
    r   = base;
    hit = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = (int'(base) + k) % CHANNELS;
      s   = m >> idx;
      if (!hit && s[0]) begin
        hit = 1'b1;
        r   = SEL_W'(idx);
      end
    end
    return r;
  endfunction

  assign sel_ok = int'(bus.sel) < CHANNELS;
  assign cur_on = bit_at(bus.en_mask, p);
  assign p_inc  = (int'(p) == CHANNELS - 1)
                ? '0 : p + SEL_W'(1);

  // Next state plus next pointer, dwell count and outputs.
  always_comb begin
    state_n = S_SCAN;
    if (!bus.mode)
      state_n = S_STATIC;
    else if (bus.en_mask == '0)
      state_n = S_EMPTY;
    p_n     = p;
    c_n     = '0;
    out_n   = '0;
    ch_n    = bus.out_ch;
    valid_n = 1'b0;
    wrap_n  = 1'b0;
    unique case (1'b1)
      state_n == S_STATIC: begin
        ch_n    = bus.sel;
        valid_n = sel_ok && bit_at(bus.en_mask, bus.sel);
        if (valid_n)
          out_n = lane(bus.x, bus.sel);
        if (sel_ok)
          p_n = bus.sel;
      end
      state_n == S_EMPTY: begin
        ch_n = bus.out_ch;
      end
      default: begin
        if (state != S_SCAN) begin
          p_n = find(p, bus.en_mask);
        end else if (!cur_on ||
                     (!bus.hold && c == C_LAST)) begin
          p_n    = find(p_inc, bus.en_mask);
          wrap_n = p_n <= p;
        end else if (!bus.hold) begin
          c_n = c + CW'(1);
        end else begin
          c_n = c;
        end
        out_n   = lane(bus.x, p_n);
        ch_n    = p_n;
        valid_n = 1'b1;
      end
    endcase
  end

  // Register state and all outputs; reset dominates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_STATIC;
      p             <= '0;
      c             <= '0;
      bus.out       <= '0;
      bus.out_ch    <= '0;
      bus.out_valid <= 1'b0;
      bus.wrap      <= 1'b0;
    end else begin
      state         <= state_n;
      p             <= p_n;
      c             <= c_n;
      bus.out       <= out_n;
      bus.out_ch    <= ch_n;
      bus.out_valid <= valid_n;
      bus.wrap      <= wrap_n;
    end
  end

endmodule
